// File: rtl/dma_word_responder.sv
// dma_word_responder: a word memory that answers DMA reads over a
// request/valid handshake after a fixed latency. A host port loads it.
// Optional build macro DMA_WORD_RESPONDER_BOUNDS_CHECK_EN turns on address
// checking. Bad requests still complete with normal timing, return zero,
// and set the sticky addr_err flag.
module dma_word_responder #(
  parameter int              RAM_WID       = 32,
  parameter int              RAM_WORD_WID  = 16,
  parameter int              RAM_WORD_INCR = 2,
  parameter int              DEPTH_WID     = 13,
  parameter longint unsigned BASE_ADDR     = 64'd0,
  parameter int              LATENCY       = 2
) (
  input  logic                    clk,
  input  logic                    rst_L,
  input  logic [RAM_WID-1:0]      ram_dma_addr,
  input  logic                    ram_read,
  output logic [RAM_WORD_WID-1:0] ram_word,
  output logic                    ram_valid,
  input  logic                    host_we,
  input  logic [DEPTH_WID-1:0]    host_waddr,
  input  logic [RAM_WORD_WID-1:0] host_wdata,
  output logic                    addr_err,
  output logic [15:0]             reads_served
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  localparam int                 LP_DEPTH     = 1 << DEPTH_WID;
  localparam logic [RAM_WID-1:0] LP_BASE      = RAM_WID'(BASE_ADDR);
  localparam logic [RAM_WID-1:0] LP_INCR      = RAM_WID'(RAM_WORD_INCR);
  // The accept edge counts as the first latency cycle.
  localparam logic [3:0]         LP_WAIT_INIT = 4'(LATENCY - 1);

  logic [RAM_WORD_WID-1:0] r_mem [LP_DEPTH];

  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [DEPTH_WID-1:0]    r_idx;
  logic [RAM_WORD_WID-1:0] r_word;
  logic                    r_valid;
  logic [15:0]             r_served;

  logic [RAM_WID-1:0]      w_off;
  logic [DEPTH_WID-1:0]    w_idx;

  // The byte offset from the base is turned into a word index. High bits
  // beyond the memory depth are dropped.
  assign w_off = ram_dma_addr - LP_BASE;
  assign w_idx = DEPTH_WID'(w_off / LP_INCR);

`ifdef DMA_WORD_RESPONDER_BOUNDS_CHECK_EN
  localparam logic [63:0] LP_SPAN = 64'(RAM_WORD_INCR) << DEPTH_WID;

  logic w_below;
  logic w_above;
  logic w_misal;
  logic w_bad;
  logic r_bad;
  logic r_addr_err;

  assign w_below  = ram_dma_addr < LP_BASE;
  assign w_above  = 64'(w_off) >= LP_SPAN;
  assign w_misal  = (w_off % LP_INCR) != {RAM_WID{1'b0}};
  assign w_bad    = w_below | w_above | w_misal;
  assign addr_err = r_addr_err;
`else
  assign addr_err = 1'b0;
`endif

  assign ram_word     = r_word;
  assign ram_valid    = r_valid;
  assign reads_served = r_served;

  // Host write port. The memory is never reset, so its contents survive rst_L.
  always_ff @(posedge clk) begin
    if (host_we) begin
      r_mem[host_waddr] <= host_wdata;
    end
  end

  // Handshake FSM. A memory read and a host write to the same index on the
  // same edge return the old data, because both use non-blocking semantics.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= {DEPTH_WID{1'b0}};
      r_word     <= {RAM_WORD_WID{1'b0}};
      r_valid    <= 1'b0;
      r_served   <= 16'd0;
`ifdef DMA_WORD_RESPONDER_BOUNDS_CHECK_EN
      r_bad      <= 1'b0;
      r_addr_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ram_read && !r_valid) begin
            r_idx   <= w_idx;
            r_cnt   <= LP_WAIT_INIT;
            r_state <= ST_WAIT;
`ifdef DMA_WORD_RESPONDER_BOUNDS_CHECK_EN
            r_bad   <= w_bad;
            if (w_bad) begin
              r_addr_err <= 1'b1;
            end
`endif
          end
        end
        ST_WAIT: begin
          // A ram_read drop here is ignored; the read always completes.
          if (r_cnt == 4'd0) begin
`ifdef DMA_WORD_RESPONDER_BOUNDS_CHECK_EN
            r_word <= r_bad ? {RAM_WORD_WID{1'b0}} : r_mem[r_idx];
`else
            r_word <= r_mem[r_idx];
`endif
            r_valid <= 1'b1;
            r_state <= ST_VALID;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_VALID: begin
          if (!ram_read) begin
            r_valid  <= 1'b0;
            r_served <= r_served + 16'd1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
